// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared state encoding and stream constants for the instruction-memory loader
package imem_loader_pkg;

  localparam logic [2:0] ST_HDR  = 3'd0;
  localparam logic [2:0] ST_DATA = 3'd1;
  localparam logic [2:0] ST_CHK  = 3'd2;
  localparam logic [2:0] ST_DONE = 3'd3;
  localparam logic [2:0] ST_ERR  = 3'd4;

  typedef enum logic [2:0] {
    HDR  = ST_HDR,
    DATA = ST_DATA,
    CHK  = ST_CHK,
    DONE = ST_DONE,
    ERR  = ST_ERR
  } state_e;

  localparam int BYTES_PER_WORD = 4;
  localparam int N_MIN          = 1;

  function automatic logic header_ok(input logic [7:0] n, input int depth);
    return (int'(n) >= N_MIN) && (int'(n) <= depth);
  endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// rtl/imem_loader_byte_packer.sv - packs bytes little-endian into 32-bit words
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  output logic        word_valid,
  output logic [31:0] word
);

  localparam int LANE_W = $clog2(BYTES_PER_WORD);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(BYTES_PER_WORD - 1);

  logic [LANE_W-1:0] lane_q, lane_d;
  logic [23:0]       hold_q, hold_d;

  // The final byte bypasses the holding register so the word is ready in the same cycle.
  always_comb begin
    lane_d     = lane_q;
    hold_d     = hold_q;
    word_valid = 1'b0;
    word       = {in_byte, hold_q};
    if (clear) begin
      lane_d = '0;
      hold_d = '0;
    end else if (in_valid) begin
      if (lane_q == LAST_LANE) begin
        word_valid = 1'b1;
        lane_d     = '0;
      end else begin
        lane_d                      = lane_q + 1'b1;
        hold_d[{lane_q, 3'b000} +: 8] = in_byte;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lane_q <= '0;
      hold_q <= '0;
    end else begin
      lane_q <= lane_d;
      hold_q <= hold_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream loader for instruction memory; holds the core in reset until loaded
// Optional trailing XOR checksum byte enabled by IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              restart,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_run,
  output logic              load_err,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int CW = ADDR_W + 1;

  state_e            state_q, state_d;
  logic              byte_ready_q, byte_ready_d;
  logic              imem_we_q, imem_we_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]       imem_wdata_q, imem_wdata_d;
  logic              core_run_q, core_run_d;
  logic              load_err_q, load_err_d;
  logic [CW-1:0]     word_cnt_q, word_cnt_d;
  logic [CW-1:0]     n_q, n_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  logic        accept;
  logic        pk_valid;
  logic        pk_clear;
  logic        word_valid;
  logic [31:0] word;
  logic        last_word;

  // restart wins over a same-cycle handshake, so that byte is never consumed.
  assign accept    = byte_valid & byte_ready_q & ~restart;
  assign pk_valid  = accept & (state_q == DATA);
  assign pk_clear  = restart | (state_q != DATA);
  assign last_word = ((word_cnt_q + CW'(1)) == n_q);

  byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (pk_clear),
    .in_valid   (pk_valid),
    .in_byte    (byte_data),
    .word_valid (word_valid),
    .word       (word)
  );

  always_comb begin
    state_d      = state_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    word_cnt_d   = word_cnt_q;
    n_d          = n_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d       = csum_q;
`endif
    case (state_q)
      HDR: begin
        if (accept) begin
          if (header_ok(byte_data, DEPTH)) begin
            n_d        = CW'(byte_data);
            word_cnt_d = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_d     = '0;
`endif
            state_d    = DATA;
          end else begin
            state_d = ERR;
          end
        end
      end
      DATA: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (pk_valid) csum_d = csum_q ^ byte_data;
`endif
        if (word_valid) begin
          imem_we_d    = 1'b1;
          imem_addr_d  = word_cnt_q[ADDR_W-1:0];
          imem_wdata_d = word;
          word_cnt_d   = word_cnt_q + CW'(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
          if (last_word) state_d = CHK;
`else
          if (last_word) state_d = DONE;
`endif
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHK: begin
        if (accept) state_d = (byte_data == csum_q) ? DONE : ERR;
      end
`endif
      default: ;
    endcase
    if (restart) begin
      state_d    = HDR;
      imem_we_d  = 1'b0;
      word_cnt_d = '0;
    end
    byte_ready_d = (state_d == HDR) || (state_d == DATA) || (state_d == CHK);
    // Lagging DONE by a cycle lets the last write land before the core leaves reset.
    core_run_d   = (state_q == DONE) && !restart;
    load_err_d   = (state_d == ERR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= HDR;
      byte_ready_q <= 1'b1;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      core_run_q   <= 1'b0;
      load_err_q   <= 1'b0;
      word_cnt_q   <= '0;
      n_q          <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      byte_ready_q <= byte_ready_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      core_run_q   <= core_run_d;
      load_err_q   <= load_err_d;
      word_cnt_q   <= word_cnt_d;
      n_q          <= n_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

  assign byte_ready   = byte_ready_q;
  assign imem_we      = imem_we_q;
  assign imem_addr    = imem_addr_q;
  assign imem_wdata   = imem_wdata_q;
  assign core_run     = core_run_q;
  assign load_err     = load_err_q;
  assign words_loaded = word_cnt_q;

endmodule
